// File: rtl/ms_pkg.sv
// ms_pkg: shared constants and types for the maze-solver path logic.
//   MAZE_DIM   - maze edge length including the border wall
//   PATH_DEPTH - interior cell count, the longest possible path
//   coord_t    - one maze coordinate
//   ms_state_t - path reverser FSM states
package ms_pkg;

  localparam int MAZE_DIM   = 15;
  localparam int PATH_DEPTH = 169;

  typedef logic [3:0] coord_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_DRAIN,
    ST_REPLAY,
    ST_DONE
  } ms_state_t;

endpackage

// File: rtl/ms_path_ram.sv
// ms_path_ram: simple dual-port path buffer, DEPTH x W.
//   clk          - clock
//   we/waddr/wdata - write port
//   re/raddr     - read request; rdata registered, held when re is low
// No reset on storage or on the read register.
module ms_path_ram #(
  parameter int DEPTH = 169,
  parameter int W     = 8,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ms_path_reverse.sv
// ms_path_reverse: collects a solved path (goal-to-start) and replays it
// start-to-goal over a valid/ready stream, then pulses done with status.
//   clk, rst               - clock, synchronous active-high reset
//   in_valid/in_nv/in_x/in_y - incoming path burst or no-path marker
//   out_valid/out_ready/out_x/out_y - reversed path stream
//   done, path_len, no_path, overflow, step_err, lost - burst status,
//                            meaningful only while done=1
// Build option: MS_PATH_STEP_CHECK_EN adds a unit-step adjacency check
// between consecutive stored coordinates (drives step_err).
module ms_path_reverse
  import ms_pkg::*;
#(
  parameter int DEPTH = PATH_DEPTH,
  parameter int CW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          in_nv,
  input  logic [CW-1:0] in_x,
  input  logic [CW-1:0] in_y,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_x,
  output logic [CW-1:0] out_y,
  output logic          done,
  output logic [7:0]    path_len,
  output logic          no_path,
  output logic          overflow,
  output logic          step_err,
  output logic          lost
);

  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam logic [CNTW-1:0] DEPTH_C = CNTW'(DEPTH);

  ms_state_t       state, state_nxt;
  logic [CNTW-1:0] count;
  logic [AW-1:0]   rd_ptr;
  logic            rd_more;   // a read is still owed for entry rd_ptr
  logic            ov_q;
  logic            no_path_q, overflow_q, lost_q;
  logic            wr_en, rd_en, accept, last_acc;
  logic [2*CW-1:0] rd_data;

  assign wr_en = in_valid &&
                 ((state == ST_IDLE && !in_nv) ||
                  (state == ST_COLLECT && count < DEPTH_C));
  assign accept = ov_q && out_ready;
  // Prefetch: fetch the next entry whenever the output slot is empty or
  // being emptied this cycle, giving one coordinate per cycle.
  assign rd_en    = (state == ST_REPLAY) && rd_more && (!ov_q || out_ready);
  // Once no read is owed, the displayed entry is entry 0.
  assign last_acc = (state == ST_REPLAY) && accept && !rd_more;

  ms_path_ram #(.DEPTH(DEPTH), .W(2*CW), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (AW'(count)),
    .wdata ({in_x, in_y}),
    .re    (rd_en),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:    if (in_valid) state_nxt = in_nv ? ST_DRAIN : ST_COLLECT;
      ST_COLLECT: if (!in_valid) state_nxt = ST_REPLAY;
      ST_DRAIN:   if (!in_valid) state_nxt = ST_DONE;
      ST_REPLAY:  if (last_acc) state_nxt = ST_DONE;
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= '0;
      rd_ptr     <= '0;
      rd_more    <= 1'b0;
      ov_q       <= 1'b0;
      no_path_q  <= 1'b0;
      overflow_q <= 1'b0;
      lost_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            if (in_nv) no_path_q <= 1'b1;
            else       count     <= CNTW'(1);
          end
        end
        ST_COLLECT: begin
          if (in_valid) begin
            if (count < DEPTH_C) count      <= count + 1'b1;
            else                 overflow_q <= 1'b1;
          end else begin
            rd_ptr  <= AW'(count - 1'b1);
            rd_more <= 1'b1;
          end
        end
        ST_REPLAY: begin
          if (in_valid) lost_q <= 1'b1;
          if (rd_en) begin
            rd_more <= (rd_ptr != '0);
            if (rd_ptr != '0) rd_ptr <= rd_ptr - 1'b1;
          end
        end
        ST_DONE: begin
          count      <= '0;
          rd_ptr     <= '0;
          rd_more    <= 1'b0;
          no_path_q  <= 1'b0;
          overflow_q <= 1'b0;
          lost_q     <= 1'b0;
        end
        default: ;
      endcase

      if (rd_en)       ov_q <= 1'b1;
      else if (accept) ov_q <= 1'b0;
    end
  end

`ifdef MS_PATH_STEP_CHECK_EN
  logic [CW-1:0] prev_x, prev_y, dx, dy;
  logic          step_bad, step_err_q;

  always_comb begin
    dx = (in_x > prev_x) ? in_x - prev_x : prev_x - in_x;
    dy = (in_y > prev_y) ? in_y - prev_y : prev_y - in_y;
    step_bad = ((CW+1)'(dx) + (CW+1)'(dy)) != (CW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_x     <= '0;
      prev_y     <= '0;
      step_err_q <= 1'b0;
    end else begin
      if (wr_en) begin
        prev_x <= in_x;
        prev_y <= in_y;
        // The first entry is written from IDLE and has no predecessor.
        if (state == ST_COLLECT && step_bad) step_err_q <= 1'b1;
      end
      if (state == ST_DONE) step_err_q <= 1'b0;
    end
  end

  assign step_err = step_err_q;
`else
  assign step_err = 1'b0;
`endif

  // Read register is unreset storage; mask it so idle outputs read zero.
  assign out_valid = ov_q;
  assign out_x     = ov_q ? rd_data[2*CW-1:CW] : '0;
  assign out_y     = ov_q ? rd_data[CW-1:0]    : '0;

  assign done     = (state == ST_DONE);
  assign path_len = done ? 8'(count) : 8'd0;
  assign no_path  = no_path_q;
  assign overflow = overflow_q;
  assign lost     = lost_q | (done && in_valid);

endmodule

// File: tb/tb_ms_path_reverse.sv
module tb_ms_path_reverse;

  localparam int DEPTH = 169;
`ifdef MS_PATH_STEP_CHECK_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, in_valid, in_nv, out_valid, out_ready, done;
  logic       no_path, overflow, step_err, lost;
  logic [3:0] in_x, in_y, out_x, out_y;
  logic [7:0] path_len;

  int n_chk = 0;
  int n_fail = 0;

  bit [3:0] bx[$];
  bit [3:0] by[$];

  always #5 clk = ~clk;

  ms_path_reverse #(.DEPTH(DEPTH), .CW(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_nv(in_nv), .in_x(in_x), .in_y(in_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
    .done(done), .path_len(path_len), .no_path(no_path),
    .overflow(overflow), .step_err(step_err), .lost(lost)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic gen_walk(input int n, input bit jumpy);
    int x, y, d;
    bx.delete(); by.delete();
    x = $urandom_range(1, 13);
    y = $urandom_range(1, 13);
    for (int i = 0; i < n; i++) begin
      bx.push_back(4'(x)); by.push_back(4'(y));
      if (jumpy && $urandom_range(7) == 0) begin
        x = $urandom_range(1, 13); y = $urandom_range(1, 13);
      end else begin
        d = ($urandom_range(1) == 0) ? 1 : -1;
        if ($urandom_range(1) == 0) begin
          if (x + d < 1 || x + d > 13) d = -d;
          x += d;
        end else begin
          if (y + d < 1 || y + d > 13) d = -d;
          y += d;
        end
      end
    end
  endtask

  task automatic drive_burst(input bit random_nv);
    for (int i = 0; i < bx.size(); i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_x = bx[i]; in_y = by[i];
      in_nv = (i > 0 && random_nv && $urandom_range(3) == 0);
    end
    @(negedge clk);
    in_valid = 1'b0; in_nv = 1'b0; in_x = '0; in_y = '0;
  endtask

  // mode 0: ready always high; 1: random ready; 2: stall 3 cycles on 2nd output
  task automatic run_burst(input string nm, input int mode, input bit inj_lost, input bit rnd_nv);
    int n, m, got, stall, first_cyc, gaps, ad;
    bit exp_step, exp_ovf, done_seen, hold, lost_done;
    bit [3:0] hx, hy, ex[$], ey[$];
    n = bx.size();
    m = (n > DEPTH) ? DEPTH : n;
    exp_ovf = (n > DEPTH);
    exp_step = 1'b0;
    for (int i = 1; i < m; i++) begin
      ad = ((bx[i] > bx[i-1]) ? bx[i] - bx[i-1] : bx[i-1] - bx[i]) +
           ((by[i] > by[i-1]) ? by[i] - by[i-1] : by[i-1] - by[i]);
      if (ad != 1) exp_step = 1'b1;
    end
    exp_step &= STEP_EN;
    ex.delete(); ey.delete();
    for (int i = m - 1; i >= 0; i--) begin ex.push_back(bx[i]); ey.push_back(by[i]); end

    out_ready = (mode == 0);
    drive_burst(rnd_nv);
    got = 0; stall = 0; first_cyc = -1; gaps = 0; hold = 0; done_seen = 0; lost_done = 0;
    for (int cyc = 1; cyc < 3000 && !done_seen; cyc++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (hold) begin
        chk({nm, " hold valid"}, out_valid, 1);
        chk({nm, " hold data"}, {out_x, out_y}, {hx, hy});
      end
      hold = 0;
      if (done) begin
        done_seen = 1;
        chk({nm, " count"}, got, m);
        chk({nm, " path_len"}, path_len, m);
        chk({nm, " overflow"}, overflow, exp_ovf);
        chk({nm, " no_path"}, no_path, 0);
        chk({nm, " step_err"}, step_err, exp_step);
        chk({nm, " lost"}, lost, inj_lost);
        chk({nm, " latency"}, first_cyc, 2);
        if (mode == 0) chk({nm, " b2b gaps"}, gaps, 0);
      end else if (out_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (inj_lost && got == 0 && !lost_done) begin in_valid = 1'b1; lost_done = 1; end
        case (mode)
          0: out_ready = 1'b1;
          1: out_ready = ($urandom_range(2) != 0);
          default: begin
            if (got == 1 && stall < 3) begin out_ready = 1'b0; stall++; end
            else out_ready = 1'b1;
          end
        endcase
        if (out_ready) begin
          if (got < m) chk({nm, " data"}, {out_x, out_y}, {ex[got], ey[got]});
          else chk({nm, " extra output"}, 1, 0);
          got++;
        end else begin
          hold = 1; hx = out_x; hy = out_y;
        end
      end else begin
        if (first_cyc >= 0) gaps++;
        out_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(1));
      end
    end
    if (!done_seen) chk({nm, " done timeout"}, 0, 1);
    @(negedge clk);
    chk({nm, " done cleared"}, done, 0);
    chk({nm, " flags cleared"}, {no_path, overflow, step_err, lost, path_len}, 0);
  endtask

  initial begin
    int waited;
    bit seen;
    rst = 1'b1; in_valid = 0; in_nv = 0; in_x = 0; in_y = 0; out_ready = 0;
    repeat (3) @(negedge clk);
    chk("rst out_valid", out_valid, 0);
    chk("rst done", done, 0);
    chk("rst outs", {out_x, out_y, path_len}, 0);
    chk("rst flags", {no_path, overflow, step_err, lost}, 0);
    rst = 1'b0;

    // three-step straight path
    bx = '{4'd3, 4'd2, 4'd1}; by = '{4'd1, 4'd1, 4'd1};
    run_burst("basic3", 0, 0, 0);

    // no-path marker
    @(negedge clk);
    in_valid = 1; in_nv = 1; in_x = 4'd7; in_y = 4'd7;
    @(negedge clk);
    in_valid = 0; in_nv = 0;
    seen = 0; waited = 0;
    while (!done && waited < 20) begin
      if (out_valid) seen = 1;
      @(negedge clk); waited++;
    end
    chk("nopath done", done, 1);
    chk("nopath no out_valid", seen, 0);
    chk("nopath flag", no_path, 1);
    chk("nopath path_len", path_len, 0);
    @(negedge clk);
    chk("nopath cleared", no_path, 0);

    // five entries with a back-pressure stall on the second output
    gen_walk(5, 0);
    run_burst("stall5", 2, 0, 0);

    // overflow: 170 entries, only the first 169 are kept
    gen_walk(170, 0);
    run_burst("ovf170", 0, 0, 0);

    // non-adjacent step
    bx = '{4'd1, 4'd3}; by = '{4'd1, 4'd1};
    run_burst("step", 0, 0, 0);

    // randomized bursts, in_nv mid-burst, some dropped inputs during replay
    for (int t = 0; t < 8; t++) begin
      gen_walk($urandom_range(1, 24), 1'(t % 2));
      run_burst($sformatf("rand%0d", t), 1, 1'(t % 3 == 0), 1);
    end

    // reset in the middle of replay
    gen_walk(5, 0);
    out_ready = 1;
    drive_burst(0);
    waited = 0; seen = 0;
    while (waited < 30 && !seen) begin
      @(negedge clk); waited++;
      if (out_valid) seen = 1;
    end
    chk("midrst reached replay", seen, 1);
    rst = 1;
    @(negedge clk);
    chk("midrst out_valid", out_valid, 0);
    chk("midrst outs", {out_x, out_y, done, path_len}, 0);
    rst = 0;
    bx = '{4'd9}; by = '{4'd4};
    run_burst("post_rst1", 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ms_path_reverse.md
MS_PATH_REVERSE -- requirements
Module: ms_path_reverse

Interface
REQ-001 SHALL have parameter DEPTH, default 169, max stored path entries (13x13 interior cells).
REQ-002 SHALL have parameter CW, default 4, coordinate width.
REQ-003 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  in  1  path coordinate or no-path marker present this cycle.
REQ-006 SHALL have port in_nv  in  1  maze-not-valid marker, qualified by in_valid.
REQ-007 SHALL have ports in_x, in_y  in  CW  path coordinate, goal-to-start order.
REQ-008 SHALL have ports out_valid  out  1, out_ready  in  1, out_x/out_y  out  CW: replayed coordinate, start-to-goal order.
REQ-009 SHALL have ports done  out  1 (one-cycle pulse), path_len  out  8, no_path, overflow, step_err, lost  out  1 each: burst status, valid only while done=1.

Function
REQ-010 SHALL implement FSM states IDLE, COLLECT, DRAIN, REPLAY, DONE.
REQ-011 IDLE: in_valid&in_nv -> DRAIN with no_path set; in_valid&!in_nv -> write entry 0, count=1, COLLECT.
REQ-012 COLLECT: each in_valid cycle writes entry at count and increments count; first in_valid-low cycle -> REPLAY.
REQ-013 COLLECT with count==DEPTH: further entries dropped, count saturates, overflow set.
REQ-014 DRAIN: ignore inputs while in_valid high; first low cycle -> DONE.
REQ-015 REPLAY: read pointer starts at count-1, decrements on each out_valid&out_ready; acceptance at pointer 0 -> DONE.
REQ-016 First out_valid SHALL assert exactly 2 cycles after the first in_valid-low cycle in COLLECT (one cycle registered buffer read).
REQ-017 out_x/out_y SHALL hold stable while out_valid&!out_ready; out_valid SHALL not drop until accepted.
REQ-018 Back-to-back acceptance SHALL sustain one coordinate per cycle (read prefetch).
REQ-019 DONE: done=1 one cycle; path_len=count (0 for no_path); flags presented; then IDLE with all flags cleared.
REQ-020 in_valid during REPLAY or DONE SHALL be dropped and set lost.
REQ-021 in_nv asserted mid-COLLECT SHALL be treated as ordinary in_valid (coordinate stored).
REQ-022 path_len SHALL be 8 bits unsigned; count SHALL never exceed DEPTH.

Reset
REQ-023 rst SHALL force IDLE, count=0, pointers=0, out_valid=0, done=0, out_x=out_y=0, path_len=0, all flags 0, effective next edge, including mid-REPLAY.
REQ-024 Buffer contents SHALL not be reset.

Configuration
REQ-025 With MS_PATH_STEP_CHECK_EN defined: each stored entry after the first SHALL be compared with the previous one; |dx|+|dy| != 1 sets step_err.
REQ-026 Without MS_PATH_STEP_CHECK_EN: step_err SHALL be tied 0 and no comparison logic built.

Structure
REQ-027 Package ms_pkg SHALL hold MAZE_DIM=15, PATH_DEPTH=169, coord_t (4-bit), and the FSM state enum.
REQ-028 Buffer SHALL be sub-module ms_path_ram: 1 write port, 1 registered read port, DEPTH x 2*CW, no reset.

Verification
REQ-029 In (3,1),(2,1),(1,1), out_ready=1 -> out (1,1),(2,1),(3,1) consecutive cycles; done, path_len=3, flags 0.
REQ-030 One-cycle in_valid with in_nv=1 -> no out_valid; done with no_path=1, path_len=0.
REQ-031 5-entry path, out_ready low 3 cycles after 2nd output -> 2nd output held 3 cycles, all 5 delivered in order, path_len=5.
REQ-032 170-entry burst -> overflow=1, path_len=169, first output = 169th input.
REQ-033 In (1,1),(3,1) -> step_err=1 with MS_PATH_STEP_CHECK_EN, 0 without; replay unaffected.
REQ-034 rst asserted mid-REPLAY -> out_valid=0 next cycle; new 1-entry burst afterwards replays correctly with path_len=1.
